// File: rtl/ex_ctrl_pipe.sv
// EX-stage control: decodes IR3 into registered ALU/memory/writeback controls,
// resolves N/Z branches with a one-cycle redirect and squashes younger slots.
module ex_ctrl_pipe #(
    parameter int DW          = 8,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       ir3,
    input  logic             ir3_valid,
    input  logic             stall,
    input  logic             n,
    input  logic             z,
    input  logic [DW-1:0]    pc,
    input  logic [DW-1:0]    se4,
    output logic [2:0]       alu_op,
    output logic [1:0]       alu2,
    output logic             flag_write,
    output logic             alu_out_write,
    output logic             mem_write,
    output logic             mdr_load,
    output logic             ir4_load,
    output logic             redirect,
    output logic [DW-1:0]    redirect_pc,
    output logic             squash,
    output logic [CNT_W-1:0] taken_count
);
    localparam int FW = (FLUSH_DEPTH < 2) ? 1 : $clog2(FLUSH_DEPTH + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t         state, state_d;
    logic [FW-1:0]  flush_cnt, flush_cnt_d;

    logic           is_alu, is_ld, is_st, is_br, br_cond;
    logic [2:0]     op_dec;
    logic [1:0]     b_dec;

    logic [2:0]       alu_op_d;
    logic [1:0]       alu2_d;
    logic             fw_d, aw_d, mw_d, ml_d, il_d, redirect_d, squash_d;
    logic [DW-1:0]    redirect_pc_d;
    logic [CNT_W-1:0] taken_count_d;

    // Instruction decode; the 3-bit shift/ori opcodes take priority over 4-bit ones.
    always_comb begin
        is_alu  = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_br   = 1'b0;
        br_cond = 1'b0;
        op_dec  = 3'b000;
        b_dec   = 2'b00;
        if (ir3[2:0] == 3'b011) begin
            is_alu = 1'b1;
            op_dec = 3'b100;
            b_dec  = 2'b11;
        end else if (ir3[2:0] == 3'b111) begin
            is_alu = 1'b1;
            op_dec = 3'b010;
            b_dec  = 2'b10;
        end else begin
            case (ir3[3:0])
                4'b0100: is_alu = 1'b1;
                4'b0110: begin is_alu = 1'b1; op_dec = 3'b001; end
                4'b1000: begin is_alu = 1'b1; op_dec = 3'b011; end
                4'b0000: is_ld = 1'b1;
                4'b0010: is_st = 1'b1;
                4'b0101: begin is_br = 1'b1; br_cond = z;  end
                4'b1001: begin is_br = 1'b1; br_cond = !z; end
                4'b1101: begin is_br = 1'b1; br_cond = !n; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state;
        flush_cnt_d   = flush_cnt;
        alu_op_d      = 3'b000;
        alu2_d        = 2'b00;
        fw_d          = 1'b0;
        aw_d          = 1'b0;
        mw_d          = 1'b0;
        ml_d          = 1'b0;
        il_d          = 1'b0;
        redirect_d    = 1'b0;
        squash_d      = 1'b0;
        redirect_pc_d = redirect_pc;
        taken_count_d = taken_count;
        if (state == FLUSH) begin
            squash_d    = 1'b1;
            flush_cnt_d = flush_cnt - FW'(1);
            if (flush_cnt == FW'(1))
                state_d = RUN;
        end else if (ir3_valid) begin
            alu_op_d = op_dec;
            alu2_d   = b_dec;
            fw_d     = is_alu;
            aw_d     = is_alu;
            mw_d     = is_st;
            ml_d     = is_ld;
            il_d     = is_alu | is_ld | is_st;
            if (is_br) begin
                // Target is relative to the fetch PC, two ahead of the branch.
                redirect_pc_d = pc - DW'(2) + se4;
                if (br_cond) begin
                    redirect_d  = 1'b1;
                    state_d     = FLUSH;
                    flush_cnt_d = FW'(FLUSH_DEPTH);
                    if (taken_count != {CNT_W{1'b1}})
                        taken_count_d = taken_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            flush_cnt     <= '0;
            alu_op        <= 3'b000;
            alu2          <= 2'b00;
            flag_write    <= 1'b0;
            alu_out_write <= 1'b0;
            mem_write     <= 1'b0;
            mdr_load      <= 1'b0;
            ir4_load      <= 1'b0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            squash        <= 1'b0;
            taken_count   <= '0;
        end else if (stall) begin
            // Everything holds except the redirect pulse, which must not repeat.
            redirect <= 1'b0;
        end else begin
            state         <= state_d;
            flush_cnt     <= flush_cnt_d;
            alu_op        <= alu_op_d;
            alu2          <= alu2_d;
            flag_write    <= fw_d;
            alu_out_write <= aw_d;
            mem_write     <= mw_d;
            mdr_load      <= ml_d;
            ir4_load      <= il_d;
            redirect      <= redirect_d;
            redirect_pc   <= redirect_pc_d;
            squash        <= squash_d;
            taken_count   <= taken_count_d;
        end
    end
endmodule
